// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Signal bundle between the MIPS pipeline datapath and the hazard/sequencing
// controller.
//   master : the datapath side. It drives the hazard-relevant fields of the
//            pipeline buffers and the memory ready flag, and it receives the
//            enables, flushes, next-PC select and status.
//   slave  : the controller side. It has the opposite directions.
// Fields:
//   id_rs, id_rt      rs/rt of the instruction in IF/ID
//   ex_memread, ex_rt load flag and destination held in ID/EX
//   mem_m, mem_zero   EX/MEM control field {jump, memwrite, memread, branch}
//                     and the ALU zero flag
//   dmem_ready        data memory completes its access this cycle
//   *_write, *_flush  buffer/PC load enables and bubble inserts
//   pc_src            0: PC+4, 1: branch target, 2: jump target
//   timeout_err, stall_cnt, flush_cnt  status
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic [3:0]       mem_m;
    logic             mem_zero;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [1:0]       pc_src;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, ex_memread, ex_rt, mem_m, mem_zero, dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, pc_src,
               timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_memread, ex_rt, mem_m, mem_zero, dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, pc_src,
               timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing controller for the 5-stage MIPS pipeline. It produces the PC and
// buffer load enables, the bubble (flush) controls and the next-PC select.
// It handles, from highest to lowest priority:
//   1. data-memory wait : freeze everything until dmem_ready. A wait that
//      lasts MAX_WAIT cycles times out and raises a sticky error.
//   2. redirect         : a taken branch or jump in EX/MEM flushes the three
//      younger slots and steers fetch.
//   3. load-use         : hold PC and IF/ID for one cycle and inject a bubble
//      into ID/EX.
// Ports:
//   clk  pipeline clock
//   rst  synchronous active-high reset. While it is high the outputs are
//        forced to load bubbles into every buffer.
//   hz   slave side of pipe_hazard_ctrl_if (see the interface for fields)
// Parameters:
//   MAX_WAIT  consecutive not-ready cycles that trigger a timeout
//   CNT_W     width of the saturating stall and flush counters
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               timeout_q;
    logic               timeout_hit;
    logic               redirect_take;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   flush_q;

    // Decoded conditions from the buffer fields.
    logic mem_access;
    logic branch_taken;
    logic jump;
    logic load_use;

    assign mem_access   = hz.mem_m[1] | hz.mem_m[2];
    assign branch_taken = hz.mem_m[0] & hz.mem_zero;
    assign jump         = hz.mem_m[3];
    // $0 is never a true dependency: it reads as zero whatever was loaded.
    assign load_use     = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                          ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

    // Combinational control outputs.
    logic       pc_write_c, ifid_write_c, idex_write_c, exmem_write_c;
    logic       ifid_flush_c, idex_flush_c, exmem_flush_c;
    logic [1:0] pc_src_c;

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave one unassigned and infer a latch.
        state_d       = state_q;
        wait_d        = wait_q;
        timeout_hit   = 1'b0;
        redirect_take = 1'b0;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        idex_write_c  = 1'b1;
        exmem_write_c = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        pc_src_c      = PC_SEQ;

        if (rst) begin
            // Load bubbles everywhere on the reset edge.
            ifid_flush_c  = 1'b1;
            idex_flush_c  = 1'b1;
            exmem_flush_c = 1'b1;
            state_d       = RUN;
            wait_d        = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_access && !hz.dmem_ready) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_write_c  = 1'b0;
                        exmem_write_c = 1'b0;
                        state_d       = MEM_WAIT;
                        wait_d        = WAIT_W'(1);
                    end else if (jump || branch_taken) begin
                        // Jump wins when both are flagged.
                        pc_src_c      = jump ? PC_JUMP : PC_BRANCH;
                        ifid_flush_c  = 1'b1;
                        idex_flush_c  = 1'b1;
                        exmem_flush_c = 1'b1;
                        redirect_take = 1'b1;
                        state_d       = REDIRECT;
                    end else if (load_use) begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_flush_c  = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    if (hz.dmem_ready) begin
                        state_d = RUN;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                        // Give up on the access: release as if it completed.
                        timeout_hit = 1'b1;
                        state_d     = RUN;
                        wait_d      = '0;
                    end else begin
                        pc_write_c    = 1'b0;
                        ifid_write_c  = 1'b0;
                        idex_write_c  = 1'b0;
                        exmem_write_c = 1'b0;
                        wait_d        = wait_q + WAIT_W'(1);
                    end
                end

                REDIRECT: begin
                    // EX/MEM holds a bubble here, so any redirect or memory
                    // field seen now is stale. Load-use is masked because
                    // IF/ID and ID/EX were just flushed.
                    state_d = RUN;
                end

                default: begin
                    state_d = RUN;
                    wait_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, wait counter and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so that every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (!pc_write_c && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redirect_take && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.idex_write  = idex_write_c;
    assign hz.exmem_write = exmem_write_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_flush  = idex_flush_c;
    assign hz.exmem_flush = exmem_flush_c;
    assign hz.pc_src      = pc_src_c;
    assign hz.timeout_err = timeout_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios with literal expectations, followed by randomized
// traffic. A behavioural model of the sequencing rules predicts the outputs
// on every falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // The pipeline is either flowing, frozen on a memory access (with the
    // count of not-ready cycles seen so far), or in the shadow cycle right
    // after a redirect. Counters are plain integers.
    // ------------------------------------------------------------------
    int m_frozen   = 0;   // not-ready cycles of the current access, 0 = none
    bit m_shadow   = 0;
    bit m_timeout  = 0;
    int m_stalls   = 0;
    int m_flushes  = 0;
    int max_cnt    = (1 << CNT_W) - 1;

    // {pc_write, ifid_write, idex_write, exmem_write,
    //  ifid_flush, idex_flush, exmem_flush, pc_src[1:0]}
    localparam logic [8:0] C_DEFAULT = 9'b1111_000_00;
    localparam logic [8:0] C_RESET   = 9'b1111_111_00;
    localparam logic [8:0] C_FREEZE  = 9'b0000_000_00;
    localparam logic [8:0] C_LOADUSE = 9'b0011_010_00;
    localparam logic [8:0] C_BRANCH  = 9'b1111_111_01;
    localparam logic [8:0] C_JUMP    = 9'b1111_111_10;

    logic [8:0] dut_ctrl;
    assign dut_ctrl = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
                       hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.pc_src};

    always @(negedge clk) begin
        logic [8:0] exp;
        bit access, redirect, hazard;
        access   = hz.mem_m[1] | hz.mem_m[2];
        redirect = hz.mem_m[3] | (hz.mem_m[0] & hz.mem_zero);
        hazard   = hz.ex_memread && hz.ex_rt != 0 &&
                   (hz.ex_rt == hz.id_rs || hz.ex_rt == hz.id_rt);

        // Registered status reflects all cycles before this one.
        check("stall_cnt", 32'(hz.stall_cnt), 32'(m_stalls));
        check("flush_cnt", 32'(hz.flush_cnt), 32'(m_flushes));
        check("timeout_err", 32'(hz.timeout_err), 32'(m_timeout));

        if (rst) begin
            exp = C_RESET;
            m_frozen = 0; m_shadow = 0; m_timeout = 0;
            m_stalls = 0; m_flushes = 0;
        end else begin
            exp = C_DEFAULT;
            if (m_shadow) begin
                m_shadow = 0;
            end else if (m_frozen > 0) begin
                if (hz.dmem_ready) begin
                    m_frozen = 0;
                end else if (m_frozen == MAX_WAIT) begin
                    m_timeout = 1;
                    m_frozen  = 0;
                end else begin
                    exp = C_FREEZE;
                    m_frozen++;
                end
            end else if (access && !hz.dmem_ready) begin
                exp = C_FREEZE;
                m_frozen = 1;
            end else if (redirect) begin
                exp = hz.mem_m[3] ? C_JUMP : C_BRANCH;
                m_shadow = 1;
                if (m_flushes < max_cnt) m_flushes++;
            end else if (hazard) begin
                exp = C_LOADUSE;
            end
            if (!exp[8] && m_stalls < max_cnt) m_stalls++;
        end
        check("ctrl", 32'(dut_ctrl), 32'(exp));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic exmr, input logic [4:0] exrt,
                         input logic [3:0] mm, input logic mz, input logic rdy);
        hz.id_rs      = rs;
        hz.id_rt      = rt;
        hz.ex_memread = exmr;
        hz.ex_rt      = exrt;
        hz.mem_m      = mm;
        hz.mem_zero   = mz;
        hz.dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Reset: bubbles forced into every buffer.
        @(negedge clk);
        check("rst_flush", 32'({hz.ifid_flush, hz.idex_flush, hz.exmem_flush}), 32'h7);
        check("rst_write", 32'({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}), 32'hF);
        next_cycle();
        rst = 1'b0;

        // Load-use: lw $8 in EX, consumer reads $8 as rs.
        drive(5'd8, 5'd3, 1'b1, 5'd8, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        check("lu_pc_write", 32'(hz.pc_write), 32'd0);
        check("lu_ifid_write", 32'(hz.ifid_write), 32'd0);
        check("lu_idex_flush", 32'(hz.idex_flush), 32'd1);
        check("lu_stall_before", 32'(hz.stall_cnt), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        check("lu_release", 32'(hz.pc_write), 32'd1);
        next_cycle();

        // $0 as load destination never stalls.
        drive(5'd0, 5'd0, 1'b1, 5'd0, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        check("r0_pc_write", 32'(hz.pc_write), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("r0_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        next_cycle();

        // Taken branch, then the shadow cycle ignores redirect and load-use.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0001, 1'b1, 1'b1);
        @(negedge clk);
        check("br_pc_src", 32'(hz.pc_src), 32'd1);
        check("br_flush", 32'({hz.ifid_flush, hz.idex_flush, hz.exmem_flush}), 32'h7);
        check("br_write", 32'({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}), 32'hF);
        next_cycle();
        drive(5'd0, 5'd5, 1'b1, 5'd5, 4'b0001, 1'b1, 1'b1);
        @(negedge clk);
        check("br_shadow_src", 32'(hz.pc_src), 32'd0);
        check("br_shadow_pcw", 32'(hz.pc_write), 32'd1);
        check("br_flush_cnt", 32'(hz.flush_cnt), 32'd1);
        next_cycle();

        // Untaken branch: no redirect.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0001, 1'b0, 1'b1);
        @(negedge clk);
        check("nt_pc_src", 32'(hz.pc_src), 32'd0);
        next_cycle();

        // Jump, then jump and taken branch together (jump wins).
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b1000, 1'b0, 1'b1);
        @(negedge clk);
        check("j_pc_src", 32'(hz.pc_src), 32'd2);
        next_cycle();
        idle();
        @(negedge clk);
        check("j_flush_cnt", 32'(hz.flush_cnt), 32'd2);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b1001, 1'b1, 1'b1);
        @(negedge clk);
        check("jb_pc_src", 32'(hz.pc_src), 32'd2);
        next_cycle();
        idle();
        @(negedge clk);
        check("jb_flush_cnt", 32'(hz.flush_cnt), 32'd3);
        next_cycle();

        // Memory wait: three not-ready cycles, then ready.
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0010, 1'b0, 1'b0);
            @(negedge clk);
            check("mw_freeze", 32'({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}), 32'h0);
            next_cycle();
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0010, 1'b0, 1'b1);
        @(negedge clk);
        check("mw_release", 32'({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}), 32'hF);
        next_cycle();
        idle();
        @(negedge clk);
        check("mw_stall_cnt", 32'(hz.stall_cnt), 32'd4);
        check("mw_timeout", 32'(hz.timeout_err), 32'd0);
        next_cycle();

        // Timeout: ready held low; four frozen cycles, release on the fifth.
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0100, 1'b0, 1'b0);
            @(negedge clk);
            check("to_freeze", 32'(hz.pc_write), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("to_release", 32'(hz.pc_write), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("to_err", 32'(hz.timeout_err), 32'd1);
        check("to_stall_cnt", 32'(hz.stall_cnt), 32'd8);
        next_cycle();
        @(negedge clk);
        check("to_sticky", 32'(hz.timeout_err), 32'd1);
        next_cycle();

        // Reset in the middle of a memory wait.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0010, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rmw_flush", 32'({hz.ifid_flush, hz.idex_flush, hz.exmem_flush}), 32'h7);
        check("rmw_write", 32'({hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}), 32'hF);
        next_cycle();
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check("rmw_run", 32'(hz.pc_write), 32'd1);
        check("rmw_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("rmw_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        check("rmw_timeout", 32'(hz.timeout_err), 32'd0);
        next_cycle();

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 6));
            next_cycle();
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath. Drives the write-enable and flush controls of the IF/ID, ID/EX and EX/MEM buffers and the PC, and selects the next-PC source. It detects load-use hazards, holds the pipeline while data memory is not ready, and redirects fetch when a branch or jump resolves at the EX/MEM stage. Sits beside the pipeline buffers; reads control fields from ID/EX and EX/MEM, emits enables, flushes and a small set of status counters.

## Interface
- MAX_WAIT, 16: maximum consecutive data-memory wait cycles before timeout.
- CNT_W, 16: width of the stall and flush counters.

- clk  in  1  pipeline clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in IF/ID.
- id_rt  in  5  rt field of the instruction in IF/ID.
- ex_memread  in  1  m[1] of the ID/EX buffer (load in EX).
- ex_rt  in  5  rt (load destination) held in ID/EX.
- mem_m  in  4  m field from EX/MEM: [0] branch, [1] memread, [2] memwrite, [3] jump.
- mem_zero  in  1  zero flag from EX/MEM.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write, idex_write, exmem_write  out  1 each  buffer load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control fields zero) into the buffer.
- pc_src  out  2  0: PC+4, 1: branch target (EX/MEM add2), 2: jump target (EX/MEM {PC[31:28], target}).
- timeout_err  out  1  sticky; set when a memory wait reaches MAX_WAIT.
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating.
- flush_cnt  out  CNT_W  redirects taken, saturating.

## Operation
- States: RUN, MEM_WAIT, REDIRECT. Outputs are combinational from state and current inputs; state, wait counter and status counters are registered.
- Default (no condition): all write enables 1, all flushes 0, pc_src=0.
- Memory access = mem_m[1] | mem_m[2]. In RUN, an access with dmem_ready=0 -> all write enables 0, no flushes; next state MEM_WAIT, wait counter <= 1.
- MEM_WAIT: all write enables 0. When dmem_ready=1 -> default outputs that cycle, next RUN. When dmem_ready=0 and wait counter = MAX_WAIT -> set timeout_err, release as if ready, next RUN; otherwise counter increments.
- Redirect (RUN, no pending memory stall): taken branch = mem_m[0] & mem_zero -> pc_src=1; jump = mem_m[3] -> pc_src=2 (jump wins if both set). Asserts ifid_flush, idex_flush, exmem_flush; enables stay 1; flush_cnt++; next REDIRECT.
- REDIRECT: one cycle; load-use detection masked; default outputs; next RUN. A redirect condition seen in REDIRECT is ignored (EX/MEM holds a bubble by construction).
- Load-use (RUN only, no memory stall, no redirect): ex_memread=1, ex_rt!=0, ex_rt equals id_rs or id_rt -> pc_write=0, ifid_write=0, idex_flush=1; other enables 1. Stays RUN; hazard clears as the load advances.
- Priority: memory stall > redirect > load-use.
- Counters saturate at all-ones, never wrap.

## Timing
- rst=1 at a posedge: state RUN, wait counter 0, timeout_err 0, stall_cnt 0, flush_cnt 0. While rst=1, outputs forced: all write enables 1, all flushes 1, pc_src=0, so the buffers clear on the same edge.
- Reset asserted during MEM_WAIT or REDIRECT returns to RUN on that edge; no pending redirect survives.
- Load-use costs exactly 1 bubble; redirect costs 3 flushed slots, no extra stall.
- Memory wait of N not-ready cycles freezes the pipeline for N cycles; dmem_ready high in the first access cycle costs 0.
- stall_cnt increments in every cycle where pc_write=0 (memory stall or load-use), updated at the following edge.

## Test plan
- Load-use: lw $8 in EX (ex_memread=1, ex_rt=8), id_rs=8 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1; next cycle default.
- ex_rt=0 with id_rs=0, ex_memread=1 -> no stall, stall_cnt stays 0.
- Taken branch: mem_m=4'b0001, mem_zero=1 -> pc_src=1, three flushes for one cycle, flush_cnt=1; jump mem_m=4'b1000 -> pc_src=2.
- Memory wait: mem_m=4'b0010, dmem_ready low 3 cycles then high -> all enables 0 for 3 cycles, release on 4th, stall_cnt=3, timeout_err=0.
- Timeout: MAX_WAIT=4, dmem_ready held low -> release after 4 wait cycles, timeout_err=1 and stays 1 until rst.
- Reset mid-MEM_WAIT: assert rst after 2 wait cycles -> next cycle state RUN, counters 0, all flushes 1 during rst.
